// File: rtl/renode_bus_responder.sv
// Bus responder for co-simulation benches: scratch registers plus an interrupt
// status/set pair, answering each access after a fixed number of wait states.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | ready for a request; accepting one latches write/addr/wdata
// S_WAIT | counting down wait states before the response
// S_RESP | response presented until the controller takes it
module renode_bus_responder #(
   parameter logic [31:0] BaseAddress     = 32'h0000_1000,
   parameter int          RegCount        = 4,
   parameter int          WaitStates      = 2,
   parameter int          InterruptsCount = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [31:0]                req_addr,
   input  logic [31:0]                req_wdata,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic                       resp_error,
   output logic [31:0]                resp_rdata,
   output logic [InterruptsCount-1:0] interrupts
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [7:0]  LP_WAIT_LOAD  = (WaitStates > 0) ? 8'(WaitStates - 1) : 8'd0;
   localparam logic [31:0] LP_STATUS_OFF = 32'(4 * RegCount);
   localparam logic [31:0] LP_SET_OFF    = 32'(4 * RegCount + 4);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [7:0]                 r_count;
   logic                       r_write;
   logic [31:0]                r_addr;
   logic [31:0]                r_wdata;
   logic [31:0]                r_regs [RegCount];
   logic [InterruptsCount-1:0] r_irq;
   logic                       r_resp_error;
   logic [31:0]                r_resp_rdata;

   logic                       w_accept;
   logic                       w_commit;
   logic                       w_cur_write;
   logic [31:0]                w_cur_addr;
   logic [31:0]                w_cur_wdata;
   logic [31:0]                w_offset;
   logic                       w_err;
   logic                       w_is_status;
   logic                       w_is_set;
   logic [31:0]                w_rdata;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      req_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = !rst;
            if (req_valid) begin
               w_accept = 1'b1;
               if (WaitStates == 0) begin
                  w_state_nxt = S_RESP;
                  w_commit    = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (r_count == 8'd0) begin
               w_state_nxt = S_RESP;
               w_commit    = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // With zero wait states the commit edge is the accept edge, so decode the live request.
   assign w_cur_write = (r_state == S_IDLE) ? req_write : r_write;
   assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

   assign w_offset    = w_cur_addr - BaseAddress;
   assign w_err       = (w_cur_addr[1:0] != 2'b00) || (w_cur_addr < BaseAddress) ||
                        (w_offset > LP_SET_OFF);
   assign w_is_status = (w_offset == LP_STATUS_OFF);
   assign w_is_set    = (w_offset == LP_SET_OFF);

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < RegCount; i++) begin
         if (w_offset == 32'(4 * i)) w_rdata = r_regs[i];
      end
      if (w_is_status) w_rdata[InterruptsCount-1:0] = r_irq;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count      <= 8'd0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_irq        <= '0;
         r_resp_error <= 1'b0;
         r_resp_rdata <= '0;
         for (int i = 0; i < RegCount; i++) r_regs[i] <= '0;
      end else begin
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_count <= LP_WAIT_LOAD;
         end else if (r_state == S_WAIT && r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
         end
         if (w_commit) begin
            r_resp_error <= w_err;
            r_resp_rdata <= (w_err || w_cur_write) ? '0 : w_rdata;
            if (!w_err && w_cur_write) begin
               for (int i = 0; i < RegCount; i++) begin
                  if (w_offset == 32'(4 * i)) r_regs[i] <= w_cur_wdata;
               end
               if (w_is_status) r_irq <= r_irq & ~w_cur_wdata[InterruptsCount-1:0];
               if (w_is_set)    r_irq <= r_irq | w_cur_wdata[InterruptsCount-1:0];
            end
         end
      end
   end

   assign resp_valid = (r_state == S_RESP);
   assign resp_error = r_resp_error;
   assign resp_rdata = r_resp_rdata;
   assign interrupts = r_irq;

endmodule

// File: tb/tb_renode_bus_responder.sv
// Bench for renode_bus_responder: one instance with two wait states, one with none,
// driven by directed and random accesses and compared against an address-map model.
module tb_renode_bus_responder;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          RC   = 4;
   localparam int          IC   = 1;
   localparam logic [31:0] MASK = 32'h0000_0001;
   localparam int          WS_A = 2;
   localparam int          WS_B = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic        req_write = 1'b0, resp_ready = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        a_req_ready, a_resp_valid, a_resp_error;
   logic        b_req_ready, b_resp_valid, b_resp_error;
   logic [31:0] a_resp_rdata, b_resp_rdata;
   logic [IC-1:0] a_irq, b_irq;

   logic        m_req_ready, m_resp_valid, m_resp_error;
   logic [31:0] m_resp_rdata, m_irq;

   int          sel = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] md_regs [2][RC];
   logic [31:0] md_irq  [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   renode_bus_responder #(.BaseAddress(BASE), .RegCount(RC), .WaitStates(WS_A),
                          .InterruptsCount(IC)) u_dut_a (
      .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_error(a_resp_error),
      .resp_rdata(a_resp_rdata), .interrupts(a_irq));

   renode_bus_responder #(.BaseAddress(BASE), .RegCount(RC), .WaitStates(WS_B),
                          .InterruptsCount(IC)) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_error(b_resp_error),
      .resp_rdata(b_resp_rdata), .interrupts(b_irq));

   always_comb begin
      m_req_ready  = (sel == 1) ? b_req_ready  : a_req_ready;
      m_resp_valid = (sel == 1) ? b_resp_valid : a_resp_valid;
      m_resp_error = (sel == 1) ? b_resp_error : a_resp_error;
      m_resp_rdata = (sel == 1) ? b_resp_rdata : a_resp_rdata;
      m_irq        = '0;
      m_irq[IC-1:0] = (sel == 1) ? b_irq : a_irq;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel == 1) b_req_valid = v;
      else          a_req_valid = v;
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         md_irq[d] = '0;
         for (int r = 0; r < RC; r++) md_regs[d][r] = '0;
      end
   endtask

   // Address-map model: applies the access to the selected device's state.
   function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                 output bit err, output logic [31:0] rd);
      logic [31:0] off;
      int          idx;
      err = 1'b0;
      rd  = '0;
      off = a - BASE;
      if (a[1:0] != 2'b00 || a < BASE || off > 32'(4 * (RC + 1))) begin
         err = 1'b1;
      end else begin
         idx = int'(off / 4);
         if (idx < RC) begin
            if (wr) md_regs[sel][idx] = wd;
            else    rd = md_regs[sel][idx];
         end else if (idx == RC) begin
            if (wr) md_irq[sel] = md_irq[sel] & ~(wd & MASK);
            else    rd = md_irq[sel];
         end else begin
            if (wr) md_irq[sel] = md_irq[sel] | (wd & MASK);
         end
      end
      if (wr) rd = '0;
   endfunction

   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold);
      bit          exp_err;
      logic [31:0] exp_rd, first_rd;
      int          k, ws, bad;
      ws = (sel == 1) ? WS_B : WS_A;
      model(wr, addr, wd, exp_err, exp_rd);
      @(negedge clk);
      k = 0;
      while (!m_req_ready && k < 50) begin @(negedge clk); k++; end
      if (!m_req_ready) chk("req_ready_wait", 32'(m_req_ready), 32'd1);
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = (hold == 0);
      set_valid(1'b1);
      @(posedge clk);
      @(negedge clk);
      set_valid(1'b0);
      k = 0;
      while (!m_resp_valid && k < 300) begin @(negedge clk); k++; end
      chk("latency", 32'(k), 32'(ws));
      chk("resp_error", 32'(m_resp_error), 32'(exp_err));
      chk("resp_rdata", m_resp_rdata, exp_rd);
      chk("interrupts", m_irq, md_irq[sel]);
      if (hold > 0) begin
         first_rd = m_resp_rdata;
         bad = 0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!m_resp_valid || m_resp_rdata !== first_rd || m_req_ready) bad++;
         end
         chk("hold_stable", 32'(bad), 32'd0);
         resp_ready = 1'b1;
      end
      @(negedge clk);
      chk("valid_drop", 32'(m_resp_valid), 32'd0);
      chk("ready_back", 32'(m_req_ready), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_in_rst", 32'(a_req_ready), 32'd0);
      model_clear();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(a_req_ready), 32'd1);
      chk("valid_after_rst", 32'(a_resp_valid), 32'd0);
      chk("rdata_after_rst", a_resp_rdata, 32'd0);
      chk("irq_after_rst", 32'(a_irq), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          bad, prev;
      bit          e;
      logic [31:0] r, a, d;
      model_clear();
      do_reset();

      sel = 0;
      do_txn(1'b1, 32'h0000_1002, 32'h1234_5678, 0);
      do_txn(1'b1, 32'h0000_1018, 32'h1234_5678, 0);
      for (int i = 0; i < RC; i++) do_txn(1'b0, BASE + 32'(4 * i), '0, 0);

      do_txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0);
      do_txn(1'b0, 32'h0000_1004, '0, 0);
      chk("deadbeef_model", md_regs[0][1], 32'hDEAD_BEEF);

      chk("irq_before_set", 32'(a_irq), 32'd0);
      do_txn(1'b1, 32'h0000_1014, 32'h1, 0);
      do_txn(1'b0, 32'h0000_1010, '0, 0);
      do_txn(1'b1, 32'h0000_1010, 32'h1, 0);
      chk("irq_cleared", 32'(a_irq), 32'd0);

      do_txn(1'b0, 32'h0000_1000, '0, 20);

      // Reset lands while the write of 0x55 is still waiting.
      sel = 0;
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h0000_1008; req_wdata = 32'h55;
      a_req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (a_resp_valid) bad++;
         @(negedge clk);
      end
      chk("no_resp_after_rst", 32'(bad), 32'd0);
      do_txn(1'b0, 32'h0000_1008, '0, 0);

      // Back-to-back writes on the zero-wait-state instance.
      sel = 1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("b2b_ready", 32'(b_req_ready), 32'd1);
      req_write = 1'b1;
      b_req_valid = 1'b1;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         req_addr  = BASE + 32'(4 * (i % RC));
         req_wdata = $urandom;
         model(1'b1, req_addr, req_wdata, e, r);
         @(posedge clk);
         @(negedge clk);
         chk("b2b_valid", 32'(b_resp_valid), 32'd1);
         chk("b2b_error", 32'(b_resp_error), 32'd0);
         if (i > 0) chk("b2b_period", 32'(cyc - prev), 32'd2);
         prev = cyc;
         if (i == 7) b_req_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      for (int i = 0; i < RC; i++) do_txn(1'b0, BASE + 32'(4 * i), '0, 0);

      for (int n = 0; n < 80; n++) begin
         sel = int'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * $urandom_range(0, RC + 1));
            6:       a = BASE + 32'(4 * $urandom_range(RC + 2, RC + 5));
            7:       a = BASE + 32'(4 * $urandom_range(0, RC + 1)) + 32'($urandom_range(1, 3));
            8:       a = BASE - 32'(4 * $urandom_range(1, 4));
            default: a = $urandom;
         endcase
         d = $urandom;
         do_txn(1'($urandom_range(0, 1)), a, d, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
